wm_cycle_ctrl: RTL

WM_CYCLE_CTRL -- requirements
Module: wm_cycle_ctrl

---
 rtl/wm_pkg.sv | 48 ++++
 rtl/wm_tick_gen.sv | 41 ++++
 rtl/wm_cycle_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/wm_pkg.sv
// Shared types, one-hot setting encodings and default phase durations for the
// washing-machine cycle controller.
package wm_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WASH   = 3'd1,
        RINSE1 = 3'd2,
        RINSE2 = 3'd3,
        DRY    = 3'd4,
        DONE   = 3'd5
    } wm_state_e;

    // water_sel is {high,mid,low}
    localparam logic [2:0] WATER_HIGH = 3'b100;
    localparam logic [2:0] WATER_MID  = 3'b010;
    localparam logic [2:0] WATER_LOW  = 3'b001;

    // temp_sel is {hot_only,cold_only,hot_cold}
    localparam logic [2:0] TEMP_HOT_ONLY  = 3'b100;
    localparam logic [2:0] TEMP_COLD_ONLY = 3'b010;
    localparam logic [2:0] TEMP_HOT_COLD  = 3'b001;

    localparam int unsigned TICK_DIV_DEF = 32'd125000000;
    localparam int unsigned WASH_T_DEF   = 32'd10;
    localparam int unsigned RINSE_T_DEF  = 32'd6;
    localparam int unsigned DRY_T_DEF    = 32'd8;

    // Illegal (non one-hot) encodings recover to the reset setting.
    function automatic logic [2:0] water_step(input logic [2:0] w);
        case (w)
            WATER_HIGH: water_step = WATER_MID;
            WATER_MID:  water_step = WATER_LOW;
            WATER_LOW:  water_step = WATER_HIGH;
            default:    water_step = WATER_HIGH;
        endcase
    endfunction

    function automatic logic [2:0] temp_step(input logic [2:0] t);
        case (t)
            TEMP_HOT_COLD:  temp_step = TEMP_HOT_ONLY;
            TEMP_HOT_ONLY:  temp_step = TEMP_COLD_ONLY;
            TEMP_COLD_ONLY: temp_step = TEMP_HOT_COLD;
            default:        temp_step = TEMP_HOT_COLD;
        endcase
    endfunction

endpackage

// File: rtl/wm_tick_gen.sv
// Tick prescaler: pulses tick_o for one cycle every TICK_DIV cycles; clr_i
// restarts the count so the next tick arrives a full period later.
module wm_tick_gen #(
    parameter int unsigned TICK_DIV = 32'd125000000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned   CW   = (TICK_DIV > 32'd1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 32'd1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // next count: wrap at LAST, forced to zero by clear
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // count register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/wm_cycle_ctrl.sv
// Washing-machine cycle sequencer: WASH, RINSE1, optional RINSE2, DRY, DONE.
// Build option WM_DRY_PHASE_EN keeps the DRY phase; without it the last rinse ends the cycle.
module wm_cycle_ctrl
    import wm_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_DEF,
    parameter int unsigned WASH_T   = WASH_T_DEF,
    parameter int unsigned RINSE_T  = RINSE_T_DEF,
    parameter int unsigned DRY_T    = DRY_T_DEF
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       btn_start,
    input  logic       btn_water,
    input  logic       btn_temp,
    input  logic       btn_repeat,
    output logic       phase_wash,
    output logic       phase_rinse,
    output logic       phase_dry,
    output logic       repeat_on,
    output logic [2:0] water_sel,
    output logic [2:0] temp_sel,
    output logic       busy,
    output logic       done,
    output logic [7:0] remain
);

`ifdef WM_DRY_PHASE_EN
    localparam wm_state_e AFTER_RINSE = DRY;
`else
    localparam wm_state_e AFTER_RINSE = DONE;
`endif

    wm_state_e  state_q, state_d;
    logic [7:0] remain_q, remain_d;
    logic [2:0] water_q, water_d;
    logic [2:0] temp_q, temp_d;
    logic       repeat_q, repeat_d;
    logic       phase_wash_q, phase_wash_d;
    logic       phase_rinse_q, phase_rinse_d;
    logic       phase_dry_q, phase_dry_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       tick_s;
    logic       clr_s;

    function automatic logic [7:0] phase_len(input wm_state_e s);
        case (s)
            WASH:           phase_len = 8'(WASH_T);
            RINSE1, RINSE2: phase_len = 8'(RINSE_T);
            DRY:            phase_len = 8'(DRY_T);
            default:        phase_len = 8'd0;
        endcase
    endfunction

    wm_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk_i  (clk),
        .rst_ni (rstn),
        .clr_i  (clr_s),
        .tick_o (tick_s)
    );

    // next-state, settings and phase timer
    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        water_d  = water_q;
        temp_d   = temp_q;
        repeat_d = repeat_q;
        clr_s    = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                // settings land on the same edge as a coincident start
                clr_s = 1'b1;
                if (btn_water) begin
                    water_d = water_step(water_q);
                end else begin
                    water_d = water_q;
                end
                if (btn_temp) begin
                    temp_d = temp_step(temp_q);
                end else begin
                    temp_d = temp_q;
                end
                if (btn_repeat) begin
                    repeat_d = ~repeat_q;
                end else begin
                    repeat_d = repeat_q;
                end
                if (btn_start) begin
                    state_d = WASH;
                end else begin
                    state_d = state_q;
                end
            end
            WASH, RINSE1, RINSE2, DRY: begin
                if (tick_s && (remain_q == 8'd1)) begin
                    clr_s = 1'b1;
                    case (state_q)
                        WASH:    state_d = RINSE1;
                        RINSE1:  state_d = repeat_q ? RINSE2 : AFTER_RINSE;
                        RINSE2:  state_d = AFTER_RINSE;
                        default: state_d = DONE;
                    endcase
                end else if (tick_s) begin
                    remain_d = remain_q - 8'd1;
                end else begin
                    remain_d = remain_q;
                end
            end
            default: begin
                state_d = IDLE;
                clr_s   = 1'b1;
            end
        endcase

        if (state_d != state_q) begin
            remain_d = phase_len(state_d);
        end else begin
            remain_d = remain_d;
        end
    end

    // output decode from the next state so every output is a flop
    always_comb begin
        phase_wash_d  = (state_d == WASH);
        phase_rinse_d = (state_d == RINSE1) || (state_d == RINSE2);
`ifdef WM_DRY_PHASE_EN
        phase_dry_d   = (state_d == DRY);
`else
        phase_dry_d   = 1'b0;
`endif
        busy_d        = (state_d == WASH) || (state_d == RINSE1) ||
                        (state_d == RINSE2) || (state_d == DRY);
        done_d        = (state_d == DONE) && (state_q != DONE);
    end

    // state, settings and output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            remain_q      <= 8'd0;
            water_q       <= WATER_HIGH;
            temp_q        <= TEMP_HOT_COLD;
            repeat_q      <= 1'b0;
            phase_wash_q  <= 1'b0;
            phase_rinse_q <= 1'b0;
            phase_dry_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            remain_q      <= remain_d;
            water_q       <= water_d;
            temp_q        <= temp_d;
            repeat_q      <= repeat_d;
            phase_wash_q  <= phase_wash_d;
            phase_rinse_q <= phase_rinse_d;
            phase_dry_q   <= phase_dry_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign phase_wash  = phase_wash_q;
    assign phase_rinse = phase_rinse_q;
    assign phase_dry   = phase_dry_q;
    assign repeat_on   = repeat_q;
    assign water_sel   = water_q;
    assign temp_sel    = temp_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign remain      = remain_q;

endmodule
